// File: rtl/line_clear_seq_if.sv
//------------------------------------------------------------------------------
// Module : line_clear_seq_if
// Brief  : Handshake, score and playfield row-port bundle for line_clear_seq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface line_clear_seq_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             busy;
  logic             done;
  logic [4:0]       lines_cleared;
  logic [9:0]       score;
  logic [4:0]       rd_row;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic [4:0]       wr_row;
  logic [WIDTH-1:0] wr_data;

  // Sequencer side
  modport master (
    input  start, rd_data,
    output busy, done, lines_cleared, score, rd_row, wr_en, wr_row, wr_data
  );

  // Game logic / playfield side
  modport slave (
    output start, rd_data,
    input  busy, done, lines_cleared, score, rd_row, wr_en, wr_row, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/line_clear_seq.sv
//------------------------------------------------------------------------------
// Module : line_clear_seq
// Brief  : Bottom-up line-clear pass: compacts surviving rows, zero-fills top.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_clear_seq #(
  parameter int WIDTH     = 10,
  parameter int DEPTH     = 20,
  parameter int SCORE_MAX = 999
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  line_clear_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EVAL = 3'd2,
    S_FILL = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [4:0]  LAST_ROW = 5'(DEPTH - 1);
  localparam logic [10:0] SAT_VAL  = 11'(SCORE_MAX);

  state_t      state_q, state_d;
  logic [4:0]  r_q, r_d;
  logic [4:0]  w_q, w_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  lines_q, lines_d;
  logic [9:0]  score_q, score_d;
  logic [10:0] sum;
  logic        row_full;

  assign row_full = &bus.rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    score_d     = score_q;
    sum         = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rd_row  = '0;
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = LAST_ROW;
          w_d     = LAST_ROW;
          cnt_d   = '0;
          state_d = S_RD;
        end
      end

      S_RD: begin
        bus.busy   = 1'b1;
        bus.rd_row = r_q;
        state_d    = S_EVAL;
      end

      S_EVAL: begin
        bus.busy   = 1'b1;
        bus.rd_row = r_q;
        if (row_full) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          w_d = w_q - 5'd1;
          // A survivor that has not moved yet is already in place.
          if (w_q != r_q) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = w_q;
            bus.wr_data = bus.rd_data;
          end
        end
        if (r_q != 5'd0) begin
          r_d     = r_q - 5'd1;
          state_d = S_RD;
        end else begin
          state_d = (cnt_d != 5'd0) ? S_FILL : S_FIN;
        end
      end

      S_FILL: begin
        bus.busy   = 1'b1;
        bus.wr_en  = 1'b1;
        bus.wr_row = w_q;
        if (w_q == 5'd0) begin
          state_d = S_FIN;
        end else begin
          w_d = w_q - 5'd1;
        end
      end

      S_FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        lines_d  = cnt_q;
        sum      = {1'b0, score_q} + {6'd0, cnt_q};
        score_d  = (sum > SAT_VAL) ? SAT_VAL[9:0] : sum[9:0];
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;

endmodule

`default_nettype wire

// File: tb/tb_line_clear_seq.sv
//------------------------------------------------------------------------------
// Module : tb_line_clear_seq
// Brief  : Directed self-checking bench with a behavioural playfield memory.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_clear_seq;

  localparam int WIDTH = 10;
  localparam int DEPTH = 20;
  localparam logic [9:0] FULL = 10'h3FF;

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic [9:0] pre  [0:DEPTH-1];
  logic [9:0] mem  [0:DEPTH-1];
  int         hits [0:DEPTH-1];
  int         hsnap[0:DEPTH-1];
  int         wcount = 0;
  int         dcount = 0;
  int         checks = 0;
  int         errors = 0;

  line_clear_seq_if #(.WIDTH(WIDTH)) bus ();

  line_clear_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCORE_MAX(999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Playfield: synchronous read (data one cycle after rd_row), synchronous write.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre[i];
    end else if (bus.wr_en && bus.wr_row < 5'(DEPTH)) begin
      mem[bus.wr_row] <= bus.wr_data;
    end
    bus.rd_data <= mem[bus.rd_row];
  end

  initial for (int i = 0; i < DEPTH; i++) hits[i] = 0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wcount = wcount + 1;
      if (bus.wr_row < 5'(DEPTH)) hits[bus.wr_row] = hits[bus.wr_row] + 1;
    end
    if (bus.done) dcount = dcount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pre(input logic [9:0] v);
    for (int i = 0; i < DEPTH; i++) pre[i] = v;
  endtask

  task automatic do_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < DEPTH; i++) hsnap[i] = hits[i];
  endtask

  function automatic int max_hits();
    int m = 0;
    for (int i = 0; i < DEPTH; i++)
      if (hits[i] - hsnap[i] > m) m = hits[i] - hsnap[i];
    return m;
  endfunction

  function automatic logic [9:0] or_rows(input int lo, input int hi);
    logic [9:0] acc = '0;
    for (int i = lo; i <= hi; i++) acc = acc | mem[i];
    return acc;
  endfunction

  // Pulse start; return cycles from the start edge to the done cycle (200 = timeout).
  task automatic run_pass(output int lat);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int w0;
  int d0;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    load      = 1'b0;
    fill_pre('0);
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_rd_row", 32'(bus.rd_row), 0);
    chk("rst_lines", 32'(bus.lines_cleared), 0);
    chk("rst_score", 32'(bus.score), 0);
    rst_n = 1'b1;
    do_load();

    // Empty playfield
    w0 = wcount;
    run_pass(lat);
    chk("empty_lat", lat, 41);
    chk("empty_writes", wcount - w0, 0);
    @(negedge clk);
    chk("empty_done_1cyc", 32'(bus.done), 0);
    chk("empty_busy_after", 32'(bus.busy), 0);
    chk("empty_lines", 32'(bus.lines_cleared), 0);
    chk("empty_score", 32'(bus.score), 0);

    // One full row at the bottom
    fill_pre('0);
    pre[19] = FULL;
    pre[18] = 10'h201;
    do_load();
    w0 = wcount; snap();
    run_pass(lat);
    chk("one_lat", lat, 42);
    @(negedge clk);
    chk("one_lines", 32'(bus.lines_cleared), 1);
    chk("one_score", 32'(bus.score), 1);
    chk("one_row19", 32'(mem[19]), 32'h201);
    chk("one_rows18_0", 32'(or_rows(0, 18)), 0);
    chk("one_writes", wcount - w0, 20);
    chk("one_max_hits", max_hits(), 1);

    // Two non-adjacent full rows
    fill_pre('0);
    pre[19] = FULL;
    pre[18] = 10'h0F0;
    pre[17] = FULL;
    pre[16] = 10'h00F;
    do_load();
    w0 = wcount; snap();
    run_pass(lat);
    chk("two_lat", lat, 43);
    @(negedge clk);
    chk("two_lines", 32'(bus.lines_cleared), 2);
    chk("two_score", 32'(bus.score), 3);
    chk("two_row19", 32'(mem[19]), 32'h0F0);
    chk("two_row18", 32'(mem[18]), 32'h00F);
    chk("two_rows17_0", 32'(or_rows(0, 17)), 0);
    chk("two_max_hits", max_hits(), 1);

    // Entire playfield full
    fill_pre(FULL);
    do_load();
    w0 = wcount; snap();
    run_pass(lat);
    chk("all_lat", lat, 61);
    @(negedge clk);
    chk("all_lines", 32'(bus.lines_cleared), 20);
    chk("all_score", 32'(bus.score), 23);
    chk("all_writes", wcount - w0, 20);
    chk("all_rows_zero", 32'(or_rows(0, 19)), 0);
    chk("all_max_hits", max_hits(), 1);

    // Asynchronous reset during EVAL of row 10 (cycle 20 after the start edge)
    fill_pre(10'h155);
    pre[19] = FULL;
    do_load();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_wr_en_pre", 32'(bus.wr_en), 1);
    chk("mid_wr_row_pre", 32'(bus.wr_row), 11);
    chk("mid_rd_row_pre", 32'(bus.rd_row), 10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_wr_en", 32'(bus.wr_en), 0);
    chk("mid_rd_row", 32'(bus.rd_row), 0);
    chk("mid_score", 32'(bus.score), 0);
    w0 = wcount;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_writes", wcount - w0, 0);
    chk("mid_idle", 32'(bus.busy), 0);

    // Start pulses during a pass are ignored
    fill_pre('0);
    do_load();
    d0 = dcount;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.start = (i == 0 || i == 5 || i == 10 || i == 30);
    end
    bus.start = 1'b0;
    chk("ignore_start_dones", dcount - d0, 1);

    // Saturation: 49 full passes + one 10-row pass = 990, then 20 more
    for (int p = 0; p < 49; p++) begin
      fill_pre(FULL);
      do_load();
      run_pass(lat);
    end
    fill_pre('0);
    for (int i = 10; i < DEPTH; i++) pre[i] = FULL;
    do_load();
    run_pass(lat);
    chk("sat_part_lat", lat, 51);
    @(negedge clk);
    chk("sat_pre_score", 32'(bus.score), 990);
    chk("sat_part_lines", 32'(bus.lines_cleared), 10);
    fill_pre(FULL);
    do_load();
    run_pass(lat);
    @(negedge clk);
    chk("sat_score", 32'(bus.score), 999);
    chk("sat_lines", 32'(bus.lines_cleared), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
